// File: rtl/semaforo_pkg.sv
// Shared encodings and default phase durations for the traffic-light controller and its lamp monitor.
package semaforo_pkg;

   localparam logic [1:0] PH_RED   = 2'd0;
   localparam logic [1:0] PH_GREEN = 2'd1;
   localparam logic [1:0] PH_AMBER = 2'd2;
   localparam logic [1:0] PH_NONE  = 2'd3;

   localparam logic [2:0] FC_NONE            = 3'd0;
   localparam logic [2:0] FC_INVALID_PATTERN = 3'd1;
   localparam logic [2:0] FC_ILLEGAL_SEQ     = 3'd2;
   localparam logic [2:0] FC_TOO_SHORT       = 3'd3;
   localparam logic [2:0] FC_TOO_LONG        = 3'd4;

   localparam int T_RED_DEF   = 200;
   localparam int T_GREEN_DEF = 90;
   localparam int T_AMBER_DEF = 3;

   typedef struct packed {
      logic r;
      logic a;
      logic v;
   } lamp_t;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_RED,
      ST_GREEN,
      ST_AMBER,
      ST_FAULT
   } mon_state_t;

endpackage

// File: rtl/semaforo_lamp_decode.sv
// Registers the r/a/v lamps once and one-hot decodes them into a phase plus an invalid flag.
// Latency: 1 clk from pins to ph_dat/invalid; no backpressure.
module semaforo_lamp_decode
   import semaforo_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       r,
   input  logic       a,
   input  logic       v,
   output logic [1:0] ph_dat,
   output logic       invalid
);

   lamp_t lamp_q, lamp_d;

   always_comb begin
      lamp_d   = '0;
      lamp_d.r = r;
      lamp_d.a = a;
      lamp_d.v = v;
   end

   always_ff @(posedge clk) begin
      if (rst) lamp_q <= '0;
      else     lamp_q <= lamp_d;
   end

   always_comb begin
      ph_dat  = PH_NONE;
      invalid = 1'b0;
      case (lamp_q)
         3'b100:  ph_dat = PH_RED;
         3'b010:  ph_dat = PH_AMBER;
         3'b001:  ph_dat = PH_GREEN;
         default: invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/semaforo_monitor.sv
// Lamp-side conflict monitor: checks pattern legality, red->green->amber order and phase durations; latches a fault code.
// Latency: fault visible 2 clk after the offending pins; no backpressure. SEMAFORO_MON_STATS_EN builds the cycles_ok counter.
module semaforo_monitor
   import semaforo_pkg::*;
#(
   parameter int T_RED   = T_RED_DEF,
   parameter int T_GREEN = T_GREEN_DEF,
   parameter int T_AMBER = T_AMBER_DEF,
   parameter int TOL     = 0,
   parameter int CW      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r,
   input  logic        a,
   input  logic        v,
   input  logic        clr_fault,
   output logic [1:0]  phase,
   output logic        fault,
   output logic [2:0]  fault_code,
   output logic        flash_req,
   output logic [15:0] cycles_ok
);

   localparam logic [CW:0] RED_MIN   = (CW+1)'(T_RED - TOL);
   localparam logic [CW:0] RED_MAX   = (CW+1)'(T_RED + TOL);
   localparam logic [CW:0] GREEN_MIN = (CW+1)'(T_GREEN - TOL);
   localparam logic [CW:0] GREEN_MAX = (CW+1)'(T_GREEN + TOL);
   localparam logic [CW:0] AMBER_MIN = (CW+1)'(T_AMBER - TOL);
   localparam logic [CW:0] AMBER_MAX = (CW+1)'(T_AMBER + TOL);

   logic [1:0]    s_ph;
   logic          s_invalid;
   mon_state_t    state_q, state_d;
   logic [CW-1:0] dur_q, dur_d;
   logic          first_red_q, first_red_d;
   logic [2:0]    code_q, code_d;
   logic [1:0]    cur_ph, succ_ph;
   mon_state_t    succ_st;
   logic [CW:0]   t_min, t_max, dur_ext, dur_inc;
`ifdef SEMAFORO_MON_STATS_EN
   logic          cycle_done;
`endif

   semaforo_lamp_decode u_decode (
      .clk     (clk),
      .rst     (rst),
      .r       (r),
      .a       (a),
      .v       (v),
      .ph_dat  (s_ph),
      .invalid (s_invalid)
   );

   always_comb begin
      cur_ph  = PH_NONE;
      succ_ph = PH_NONE;
      succ_st = ST_SYNC;
      t_min   = '0;
      t_max   = '0;
      case (state_q)
         ST_RED:   begin cur_ph = PH_RED;   succ_ph = PH_GREEN; succ_st = ST_GREEN; t_min = RED_MIN;   t_max = RED_MAX;   end
         ST_GREEN: begin cur_ph = PH_GREEN; succ_ph = PH_AMBER; succ_st = ST_AMBER; t_min = GREEN_MIN; t_max = GREEN_MAX; end
         ST_AMBER: begin cur_ph = PH_AMBER; succ_ph = PH_RED;   succ_st = ST_RED;   t_min = AMBER_MIN; t_max = AMBER_MAX; end
         default:  ;
      endcase
   end

   // One extra bit so dur+1 never wraps before the too-long compare.
   assign dur_ext = {1'b0, dur_q};
   assign dur_inc = dur_ext + (CW+1)'(1);

   always_comb begin
      state_d     = state_q;
      dur_d       = dur_q;
      first_red_d = first_red_q;
      code_d      = code_q;
`ifdef SEMAFORO_MON_STATS_EN
      cycle_done  = 1'b0;
`endif
      case (state_q)
         ST_SYNC: begin
            if (s_ph == PH_RED) begin
               state_d     = ST_RED;
               dur_d       = CW'(1);
               first_red_d = 1'b1;
            end
         end
         ST_RED, ST_GREEN, ST_AMBER: begin
            if (s_invalid) begin
               state_d = ST_FAULT;
               code_d  = FC_INVALID_PATTERN;
            end else if (s_ph != cur_ph && s_ph != succ_ph) begin
               state_d = ST_FAULT;
               code_d  = FC_ILLEGAL_SEQ;
            end else if (s_ph != cur_ph && dur_ext < t_min &&
                         !(state_q == ST_RED && first_red_q)) begin
               state_d = ST_FAULT;
               code_d  = FC_TOO_SHORT;
            end else if (s_ph == cur_ph && dur_inc > t_max) begin
               state_d = ST_FAULT;
               code_d  = FC_TOO_LONG;
            end else if (s_ph != cur_ph) begin
               state_d     = succ_st;
               dur_d       = CW'(1);
               first_red_d = 1'b0;
`ifdef SEMAFORO_MON_STATS_EN
               cycle_done  = (state_q == ST_AMBER);
`endif
            end else if (!(&dur_q)) begin
               dur_d = dur_q + CW'(1);
            end
         end
         ST_FAULT: begin
            if (clr_fault) begin
               state_d = ST_SYNC;
               code_d  = FC_NONE;
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SYNC;
         dur_q       <= '0;
         first_red_q <= 1'b0;
         code_q      <= FC_NONE;
      end else begin
         state_q     <= state_d;
         dur_q       <= dur_d;
         first_red_q <= first_red_d;
         code_q      <= code_d;
      end
   end

   always_comb begin
      phase = PH_NONE;
      case (state_q)
         ST_RED:   phase = PH_RED;
         ST_GREEN: phase = PH_GREEN;
         ST_AMBER: phase = PH_AMBER;
         default:  phase = PH_NONE;
      endcase
   end

   assign fault      = (state_q == ST_FAULT);
   assign flash_req  = (state_q == ST_FAULT);
   assign fault_code = code_q;

`ifdef SEMAFORO_MON_STATS_EN
   logic [15:0] cycles_q, cycles_d;

   always_comb cycles_d = cycle_done ? cycles_q + 16'd1 : cycles_q;

   always_ff @(posedge clk) begin
      if (rst) cycles_q <= '0;
      else     cycles_q <= cycles_d;
   end

   assign cycles_ok = cycles_q;
`else
   assign cycles_ok = '0;
`endif

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor: directed lamp sequences push timed expectations, a negedge monitor pops and compares.
module tb_semaforo_monitor;
   import semaforo_pkg::*;

`ifdef SEMAFORO_MON_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] AMB = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   logic        clk = 1'b0;
   logic        rst, r, a, v, clr_fault;
   logic [1:0]  phase;
   logic        fault;
   logic [2:0]  fault_code;
   logic        flash_req;
   logic [15:0] cycles_ok;

   semaforo_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .r          (r),
      .a          (a),
      .v          (v),
      .clr_fault  (clr_fault),
      .phase      (phase),
      .fault      (fault),
      .fault_code (fault_code),
      .flash_req  (flash_req),
      .cycles_ok  (cycles_ok)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [1:0]  ph;
      logic        flt;
      logic [2:0]  code;
      logic        flash;
      logic [15:0] cok;
   } obs_t;

   typedef struct {
      int   at;
      obs_t exp;
   } chk_t;

   chk_t  exp_q[$];
   string name_q[$];
   int    n_vec = 0;
   int    n_bad = 0;

   function automatic logic [15:0] ck(input int n);
      return STATS ? 16'(n) : 16'd0;
   endfunction

   task automatic expect_obs(input int dt, input logic [1:0] ph, input logic [2:0] code,
                             input logic [15:0] cok, input string nm);
      chk_t c;
      c.at        = cyc + dt;
      c.exp.ph    = ph;
      c.exp.flt   = (code != FC_NONE);
      c.exp.code  = code;
      c.exp.flash = (code != FC_NONE);
      c.exp.cok   = cok;
      exp_q.push_back(c);
      name_q.push_back(nm);
   endtask

   task automatic hold(input logic [2:0] rav, input int n);
      {r, a, v} = rav;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clr();
      clr_fault = 1'b1;
      expect_obs(1, PH_NONE, FC_NONE, ck(3), "clr_keeps_cycles");
      hold(3'b000, 1);
      clr_fault = 1'b0;
   endtask

   always @(negedge clk) begin
      obs_t  act;
      chk_t  c;
      string nm;
      act.ph    = phase;
      act.flt   = fault;
      act.code  = fault_code;
      act.flash = flash_req;
      act.cok   = cycles_ok;
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
         c  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_vec++;
         if (c.at < cyc) begin
            n_bad++;
            $display("FAIL %s: checkpoint for cycle %0d not sampled (now %0d)", nm, c.at, cyc);
         end else if (act !== c.exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got phase=%0d fault=%0b code=%0d flash=%0b cycles_ok=%0d, expected phase=%0d fault=%0b code=%0d flash=%0b cycles_ok=%0d",
                     nm, cyc, act.ph, act.flt, act.code, act.flash, act.cok,
                     c.exp.ph, c.exp.flt, c.exp.code, c.exp.flash, c.exp.cok);
         end
      end
   end

   initial begin
      rst = 1'b1; clr_fault = 1'b0; {r, a, v} = 3'b000;
      @(negedge clk); @(negedge clk);
      expect_obs(1, PH_NONE, FC_NONE, 16'd0, "reset_state");
      @(negedge clk);
      rst = 1'b0;

      // Three nominal red/green/amber cycles from power-up.
      for (int k = 0; k < 3; k++) begin
         expect_obs(2, PH_RED, FC_NONE, ck(k), "nominal_red");
         hold(RED, 200);
         if (k == 0) expect_obs(1, PH_RED, FC_NONE, ck(k), "green_lag");
         expect_obs(2, PH_GREEN, FC_NONE, ck(k), "nominal_green");
         hold(GRN, 90);
         expect_obs(2, PH_AMBER, FC_NONE, ck(k), "nominal_amber");
         hold(AMB, 3);
      end
      expect_obs(2, PH_RED, FC_NONE, ck(3), "three_cycles_done");
      hold(RED, 200);

      // Green cut to 85 cycles.
      expect_obs(2, PH_GREEN, FC_NONE, ck(3), "green_before_short");
      hold(GRN, 85);
      expect_obs(1, PH_GREEN, FC_NONE, ck(3), "pre_too_short");
      expect_obs(2, PH_NONE, FC_TOO_SHORT, ck(3), "too_short");
      hold(AMB, 3);
      expect_obs(3, PH_NONE, FC_TOO_SHORT, ck(3), "fault_ignores_lamps");
      hold(3'b111, 4);
      pulse_clr();

      // Resync on a partial 50-cycle red, then amber held 5 cycles.
      expect_obs(2, PH_RED, FC_NONE, ck(3), "resync_red");
      hold(RED, 50);
      expect_obs(2, PH_GREEN, FC_NONE, ck(3), "first_red_50_ok");
      hold(GRN, 90);
      expect_obs(4, PH_AMBER, FC_NONE, ck(3), "amber_3rd_ok");
      expect_obs(5, PH_NONE, FC_TOO_LONG, ck(3), "too_long");
      hold(AMB, 5);
      pulse_clr();

      // r+a glitch mid-green.
      hold(RED, 50);
      hold(GRN, 40);
      expect_obs(1, PH_GREEN, FC_NONE, ck(3), "pre_invalid");
      expect_obs(2, PH_NONE, FC_INVALID_PATTERN, ck(3), "invalid_ra");
      hold(3'b110, 1);
      hold(GRN, 3);
      pulse_clr();

      // Red straight to amber.
      hold(RED, 30);
      expect_obs(1, PH_RED, FC_NONE, ck(3), "pre_illegal");
      expect_obs(2, PH_NONE, FC_ILLEGAL_SEQ, ck(3), "red_to_amber");
      hold(AMB, 3);
      pulse_clr();

      // Reset while green with dur=40.
      hold(RED, 30);
      expect_obs(41, PH_GREEN, FC_NONE, ck(3), "green_dur40");
      expect_obs(42, PH_NONE, FC_NONE, 16'd0, "rst_in_green");
      hold(GRN, 41);
      rst = 1'b1;
      hold(GRN, 1);
      rst = 1'b0;

      // One full cycle, fault, then rst and clr_fault together.
      hold(RED, 20);
      hold(GRN, 90);
      hold(AMB, 3);
      expect_obs(2, PH_RED, FC_NONE, ck(1), "cycle_after_rst");
      hold(RED, 5);
      expect_obs(2, PH_NONE, FC_INVALID_PATTERN, ck(1), "invalid_111");
      hold(3'b111, 3);
      rst = 1'b1; clr_fault = 1'b1;
      expect_obs(1, PH_NONE, FC_NONE, 16'd0, "rst_and_clr");
      expect_obs(2, PH_NONE, FC_NONE, 16'd0, "rst_clears_sample");
      expect_obs(3, PH_RED, FC_NONE, 16'd0, "resync_after_rst");
      hold(RED, 1);
      rst = 1'b0; clr_fault = 1'b0;
      hold(RED, 4);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      while (exp_q.size() > 0) begin
         chk_t  c;
         string nm;
         c  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_vec++;
         n_bad++;
         $display("FAIL %s: checkpoint for cycle %0d never reached (now %0d)", nm, c.at, cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
